// File: rtl/memory_instr_issuer.sv
// Program sequencer feeding the memory block from a synchronous instruction ROM.
// Define ISSUER_PERF_COUNT_EN to add the issued/stall performance counter ports.
module memory_instr_issuer #(
  parameter int  INSTRUCTION_WIDTH = 32,
  parameter int  INSTRUCTION_COUNT = 8,
  parameter int  WAIT_WIDTH        = 8,
  localparam int PC_WIDTH          = $clog2(INSTRUCTION_COUNT)
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         start_in,
  input  logic                         mem_idle_in,
  output logic [PC_WIDTH-1:0]          prog_addr_out,
  input  logic [0:INSTRUCTION_WIDTH-1] prog_data_in,
  output logic [0:INSTRUCTION_WIDTH-1] instr_out,
  output logic                         instr_valid_out,
  output logic [PC_WIDTH-1:0]          pc_out,
  output logic                         busy_out,
  output logic                         done_out,
  output logic [2:0]                   dbg_state_out
`ifdef ISSUER_PERF_COUNT_EN
  ,
  output logic [15:0]                  issued_count_out,
  output logic [15:0]                  stall_count_out
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                         r_state;
  logic [PC_WIDTH-1:0]            r_pc;
  logic [0:INSTRUCTION_WIDTH-1]   r_instr;
  logic                           r_instr_valid;
  logic                           r_done;
  logic [WAIT_WIDTH-1:0]          r_wait_cnt;
  logic                           r_wait_last;

  logic [3:0]                     w_op;
  logic [WAIT_WIDTH-1:0]          w_wait_n;
  logic                           w_is_mem;
  logic                           w_is_wait;
  logic                           w_is_end;
  logic                           w_last;
  logic                           w_stall;
  logic                           w_advance;
  logic                           w_start_ok;

  assign w_op       = prog_data_in[0:3];
  assign w_wait_n   = prog_data_in[4:4+WAIT_WIDTH-1];
  assign w_is_mem   = (w_op == 4'b0000) || (w_op == 4'b0110) || (w_op == 4'b0111) ||
                      (w_op == 4'b1000) || (w_op == 4'b1001) || (w_op == 4'b1010);
  assign w_is_wait  = (w_op == 4'b0001);
  assign w_is_end   = (w_op == 4'b1111);
  assign w_last     = (r_pc == PC_WIDTH'(INSTRUCTION_COUNT - 1));
  assign w_start_ok = start_in && ((r_state == S_IDLE) || (r_state == S_DONE));

  // Handshake: memory consumes instr_out on every cycle instr_valid_out=1; mem_idle_in
  // only gates memory ops sitting in ISSUE, local ops (WAIT/END/unknown) never wait on it.
  assign w_stall   = (r_state == S_ISSUE) && w_is_mem && !mem_idle_in;
  assign w_advance = (r_state == S_ISSUE) && !w_stall && !w_is_end;

  // Next-PC address so the ROM word for the following ISSUE cycle is ready in time.
  always_comb begin
    prog_addr_out = '0;
    case (r_state)
      S_FETCH: prog_addr_out = r_pc;
      S_ISSUE: prog_addr_out = w_advance ? (r_pc + PC_WIDTH'(1)) : r_pc;
      S_WAIT:  prog_addr_out = r_pc;
      default: prog_addr_out = '0;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state       <= S_IDLE;
      r_pc          <= '0;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_done        <= 1'b0;
      r_wait_cnt    <= '0;
      r_wait_last   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_instr_valid <= 1'b0;
          if (start_in) begin
            r_state <= S_FETCH;
            r_pc    <= '0;
            r_done  <= 1'b0;
          end
        end
        S_FETCH: begin
          r_instr_valid <= 1'b0;
          r_state       <= S_ISSUE;
        end
        S_ISSUE: begin
          if (w_is_end) begin
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_done        <= 1'b0 | 1'b1;
            r_state       <= S_DONE;
          end else if (w_stall) begin
            r_instr_valid <= 1'b0;
          end else begin
            r_pc          <= r_pc + PC_WIDTH'(1);
            r_instr_valid <= 1'b1;
            r_instr       <= w_is_mem ? prog_data_in : '0;
            // WAIT N: this cycle is the first NOP, the WAIT state supplies the other N-1.
            if (w_is_wait && (w_wait_n > WAIT_WIDTH'(1))) begin
              r_wait_cnt  <= w_wait_n - WAIT_WIDTH'(1);
              r_wait_last <= w_last;
              r_state     <= S_WAIT;
            end else if (w_last) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_WAIT: begin
          r_instr       <= '0;
          r_instr_valid <= 1'b1;
          r_wait_cnt    <= r_wait_cnt - WAIT_WIDTH'(1);
          if (r_wait_cnt == WAIT_WIDTH'(1)) begin
            if (r_wait_last) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_ISSUE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign instr_out       = r_instr;
  assign instr_valid_out = r_instr_valid;
  assign pc_out          = r_pc;
  assign done_out        = r_done;
  assign busy_out        = (r_state == S_FETCH) || (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign dbg_state_out   = r_state;

`ifdef ISSUER_PERF_COUNT_EN
  logic [15:0] r_issued_cnt;
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_issued_cnt <= '0;
      r_stall_cnt  <= '0;
    end else if (w_start_ok) begin
      r_issued_cnt <= '0;
      r_stall_cnt  <= '0;
    end else begin
      if (r_instr_valid && (r_issued_cnt != 16'hFFFF))
        r_issued_cnt <= r_issued_cnt + 16'd1;
      if ((r_state == S_ISSUE) && !mem_idle_in && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign issued_count_out = r_issued_cnt;
  assign stall_count_out  = r_stall_cnt;
`else
  logic w_unused_start;
  assign w_unused_start = w_start_ok;
`endif

endmodule

// File: tb/tb_memory_instr_issuer.sv
// Bench for memory_instr_issuer: directed programs plus randomized ROM/back-pressure runs
// compared cycle by cycle against a program-cursor reference model.
module tb_memory_instr_issuer;

  localparam int ROM_N = 16;
  localparam int MAXC  = 128;

  logic        clk;
  logic        rst_in;
  logic        start_in;
  logic        mem_idle_in;
  logic [3:0]  prog_addr;
  logic [0:31] prog_data;
  logic [0:31] instr;
  logic        valid;
  logic [3:0]  pc;
  logic        busy;
  logic        done;
  logic [2:0]  dbg_state;
`ifdef ISSUER_PERF_COUNT_EN
  logic [15:0] issued_cnt;
  logic [15:0] stall_cnt;
`endif

  memory_instr_issuer #(
    .INSTRUCTION_WIDTH (32),
    .INSTRUCTION_COUNT (ROM_N),
    .WAIT_WIDTH        (8)
  ) dut (
    .clk_in          (clk),
    .rst_in          (rst_in),
    .start_in        (start_in),
    .mem_idle_in     (mem_idle_in),
    .prog_addr_out   (prog_addr),
    .prog_data_in    (prog_data),
    .instr_out       (instr),
    .instr_valid_out (valid),
    .pc_out          (pc),
    .busy_out        (busy),
    .done_out        (done),
    .dbg_state_out   (dbg_state)
`ifdef ISSUER_PERF_COUNT_EN
    ,
    .issued_count_out(issued_cnt),
    .stall_count_out (stall_cnt)
`endif
  );

  // clock / reset block and synchronous ROM
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [0:31] rom [ROM_N];
  always @(posedge clk) prog_data <= rom[prog_addr];

  // stimulus patterns per cycle of a run
  bit start_pat [MAXC];
  bit idle_pat  [MAXC];

  // reference model: program cursor, pending NOP count, expected outputs
  bit          m_busy;
  bit          m_fetch;
  int          m_cur;
  int          m_nop;
  logic [0:31] e_word;
  bit          e_valid;
  bit          e_done;
  int          e_issued;
  int          e_stall;

  int n_checks;
  int n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [0:31] mk(input logic [3:0] op, input logic [7:0] n, input logic [19:0] lo);
    logic [0:31] w;
    w = {op, n, lo};
    return w;
  endfunction

  function automatic bit is_mem(input logic [3:0] op);
    return op inside {4'h0, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA};
  endfunction

  task automatic model_reset();
    m_busy = 0; m_fetch = 0; m_cur = 0; m_nop = 0;
    e_word = '0; e_valid = 0; e_done = 0; e_issued = 0; e_stall = 0;
  endtask

  // Predicts the outputs after the coming clock edge from the inputs now applied.
  task automatic model_eval();
    logic [0:31] w;
    logic [3:0]  op;
    int          n;
    bit          was_valid;
    was_valid = e_valid;
    if (was_valid) e_issued++;
    if (!m_busy) begin
      e_valid = 0;
      if (start_in) begin
        m_busy = 1; m_fetch = 1; m_cur = 0; m_nop = 0;
        e_done = 0; e_issued = 0; e_stall = 0;
      end
    end else if (m_fetch) begin
      m_fetch = 0;
      e_valid = 0;
    end else if (m_nop > 0) begin
      e_valid = 1; e_word = '0; m_nop--;
      if (m_nop == 0 && m_cur == ROM_N) begin m_busy = 0; e_done = 1; end
    end else begin
      w  = rom[m_cur];
      op = w[0:3];
      n  = int'(w[4:11]);
      if (!mem_idle_in) e_stall++;
      if (op == 4'hF) begin
        e_valid = 0; e_word = '0; m_busy = 0; e_done = 1;
      end else if (is_mem(op) && !mem_idle_in) begin
        e_valid = 0;
      end else begin
        e_valid = 1;
        e_word  = is_mem(op) ? w : '0;
        m_cur++;
        if (op == 4'h1 && n > 1) m_nop = n - 1;
        if (m_cur == ROM_N && m_nop == 0) begin m_busy = 0; e_done = 1; end
      end
    end
  endtask

  task automatic check_all();
    check("valid", 32'(valid), 32'(e_valid));
    check("instr", instr, e_word);
    check("done", 32'(done), 32'(e_done));
    check("busy", 32'(busy), 32'(m_busy));
    if (m_busy) check("pc", 32'(pc), 32'(m_cur % ROM_N));
`ifdef ISSUER_PERF_COUNT_EN
    check("issued_cnt", 32'(issued_cnt), 32'(e_issued));
    check("stall_cnt", 32'(stall_cnt), 32'(e_stall));
`endif
  endtask

  task automatic clear_pats();
    for (int c = 0; c < MAXC; c++) begin
      start_pat[c] = 0;
      idle_pat[c]  = 1;
    end
    start_pat[0] = 1;
  endtask

  // driver: called at a negedge, runs len cycles checking every one
  task automatic run(input int len, output int n_valid, output int first_valid, output int n_pc3_hold);
    n_valid = 0; first_valid = -1; n_pc3_hold = 0;
    for (int c = 0; c < len; c++) begin
      start_in    = start_pat[c];
      mem_idle_in = idle_pat[c];
      model_eval();
      @(negedge clk);
      check_all();
      if (valid) begin
        n_valid++;
        if (first_valid < 0) first_valid = c;
      end
      if (!valid && busy && pc == 4'd3) n_pc3_hold++;
    end
    start_in    = 0;
    mem_idle_in = 1;
  endtask

  task automatic load_straight();
    for (int i = 0; i < ROM_N; i++) rom[i] = mk(4'hF, 8'd0, 20'd0);
    rom[0] = mk(4'h6, 8'd1, 20'd0);
    for (int i = 1; i <= 6; i++) rom[i] = mk(4'h7, 8'(i), 20'h00055);
    rom[7] = mk(4'h8, 8'd0, 20'd0);
    rom[8] = mk(4'hA, 8'd1, 20'd0);
    rom[9] = mk(4'hF, 8'd0, 20'd0);
  endtask

  int nv, fv, np;
  int nzero;

  initial begin
    n_checks = 0; n_fail = 0;
    rst_in = 0; start_in = 0; mem_idle_in = 1;
    for (int i = 0; i < ROM_N; i++) rom[i] = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    check("reset_instr", instr, 32'd0);
    rst_in = 1;

    // straight-line program, no back-pressure
    load_straight();
    clear_pats();
    run(16, nv, fv, np);
    check("t1_first_valid", 32'(fv), 32'd2);
    check("t1_valid_cycles", 32'(nv), 32'd9);
    check("t1_done", 32'(done), 32'd1);

    // back-pressure on LOADI #3
    clear_pats();
    idle_pat[5] = 0; idle_pat[6] = 0; idle_pat[7] = 0;
    run(18, nv, fv, np);
    check("t2_valid_cycles", 32'(nv), 32'd9);
    check("t2_pc3_frozen", 32'(np), 32'd3);
`ifdef ISSUER_PERF_COUNT_EN
    check("t2_issued_total", 32'(issued_cnt), 32'd9);
    check("t2_stall_total", 32'(stall_cnt), 32'd3);
`endif

    // WAIT N=4 and WAIT N=0
    for (int i = 0; i < ROM_N; i++) rom[i] = mk(4'hF, 8'd0, 20'd0);
    rom[0] = mk(4'h6, 8'd1, 20'd0);
    rom[1] = mk(4'hA, 8'd1, 20'd0);
    rom[2] = mk(4'h1, 8'd4, 20'd0);
    rom[3] = mk(4'h9, 8'd2, 20'd0);
    rom[4] = mk(4'h1, 8'd0, 20'd0);
    rom[5] = mk(4'h7, 8'd9, 20'd0);
    clear_pats();
    nzero = 0;
    run(16, nv, fv, np);
    check("t3_valid_cycles", 32'(nv), 32'd9);
    check("t3_done", 32'(done), 32'd1);

    // no END: runs to the last ROM word, start during run ignored, start in DONE reruns
    for (int i = 0; i < ROM_N; i++) rom[i] = mk(4'h7, 8'(i), 20'($urandom));
    clear_pats();
    start_pat[6]  = 1;
    start_pat[25] = 1;
    run(46, nv, fv, np);
    check("t4_valid_cycles", 32'(nv), 32'(2 * ROM_N));
    check("t4_done", 32'(done), 32'd1);

    // start in the same cycle END issues: END wins
    for (int i = 0; i < ROM_N; i++) rom[i] = mk(4'hF, 8'd0, 20'd0);
    rom[0] = mk(4'h6, 8'd3, 20'd0);
    clear_pats();
    start_pat[3] = 1;
    run(8, nv, fv, np);
    check("t5_busy_after_end", 32'(busy), 32'd0);
    check("t5_done_after_end", 32'(done), 32'd1);

    // asynchronous reset mid-program, then a clean restart from pc 0
    load_straight();
    clear_pats();
    run(6, nv, fv, np);
    #2 rst_in = 0;
    #1;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    model_reset();
    @(negedge clk);
    rst_in = 1;
    clear_pats();
    run(16, nv, fv, np);
    check("t6_first_valid", 32'(fv), 32'd2);
    check("t6_valid_cycles", 32'(nv), 32'd9);

    // randomized ROM, back-pressure and start pulses
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < ROM_N; i++) begin
        logic [3:0] op;
        op = 4'($urandom_range(0, 15));
        if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h7;
        rom[i] = mk(op, (op == 4'h1) ? 8'($urandom_range(0, 5)) : 8'($urandom), 20'($urandom));
      end
      clear_pats();
      for (int c = 1; c < MAXC; c++) begin
        start_pat[c] = ($urandom_range(0, 19) == 0);
        idle_pat[c]  = ($urandom_range(0, 3) != 0);
      end
      run(MAXC, nv, fv, np);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
